// File: rtl/chip8_timebase_pkg.sv
// Shared constants for the CHIP-8 timebase: default sizes, reset-source
// polarity and the fixed meaning of each clock-enable channel.
package chip8_pkg;

    localparam int NUM_CH_DEFAULT  = 4;
    localparam int ACC_W_DEFAULT   = 24;
    localparam int RST_LEN_DEFAULT = 16;
    localparam int RST_SRC_DEFAULT = 3;

    // Button and download requests fire on a rise, the error line on a fall.
    localparam logic [2:0] RST_EDGE_DEFAULT = 3'b011;

    // Channel assignment inside the ce vector.
    localparam int CH_CPU_FAST = 0;
    localparam int CH_CPU_SLOW = 1;
    localparam int CH_TIMER    = 2;
    localparam int CH_AUDIO    = 3;

    // Width of a counter that must be able to hold the value len.
    function automatic int stretch_cnt_w(input int len);
        return (len < 1) ? 1 : $clog2(len + 1);
    endfunction

endpackage

// File: rtl/chip8_timebase_if.sv
// Configuration and output bundle of the timebase. There is no valid/ready
// handshake: configuration inputs are levels sampled every clk_sys cycle,
// ce is a one-cycle strobe per channel and rst_out is a level.
interface chip8_timebase_if
    import chip8_pkg::*;
#(
    parameter int NUM_CH  = NUM_CH_DEFAULT,
    parameter int ACC_W   = ACC_W_DEFAULT,
    parameter int RST_SRC = RST_SRC_DEFAULT
);
    logic [NUM_CH*ACC_W-1:0] num_cfg;
    logic [NUM_CH*ACC_W-1:0] den_cfg;
    logic [NUM_CH-1:0]       hold;
    logic [RST_SRC-1:0]      rst_src;
    logic [NUM_CH-1:0]       ce;
    logic                    rst_out;

    // Controller side: drives configuration, observes enables and reset.
    modport master (
        output num_cfg, den_cfg, hold, rst_src,
        input  ce, rst_out
    );

    // Timebase side.
    modport slave (
        input  num_cfg, den_cfg, hold, rst_src,
        output ce, rst_out
    );
endinterface

// File: rtl/chip8_timebase_frac_ce.sv
// One fractional clock-enable channel: ce averages num/den of clk_sys with
// no drift, because the remainder is carried in acc from pulse to pulse.
module chip8_frac_ce
    import chip8_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEFAULT
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic [ACC_W-1:0] num,
    input  logic [ACC_W-1:0] den,
    input  logic             hold,
    output logic             ce
);
    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] acc_plus;
    logic [ACC_W-1:0] acc_wrap;

    // acc+num needs one extra bit so the compare against den never wraps.
    // The subtract result is always below den, so ACC_W bits hold it exactly.
    always_comb begin
        sum      = {1'b0, acc} + {1'b0, num};
        acc_plus = acc + num;
        acc_wrap = acc + num - den;
    end

    // Accumulate, emit a pulse on each wrap past den, freeze while held.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            acc <= '0;
            ce  <= 1'b0;
        end else if (hold) begin
            ce  <= 1'b0;
        end else if (den == '0) begin
            acc <= '0;
            ce  <= 1'b0;
        end else if (acc >= den) begin
            // Stale phase left over from a smaller den: restart cleanly.
            acc <= '0;
            ce  <= 1'b0;
        end else if (num >= den) begin
            acc <= '0;
            ce  <= 1'b1;
        end else if (sum >= {1'b0, den}) begin
            acc <= acc_wrap;
            ce  <= 1'b1;
        end else begin
            acc <= acc_plus;
            ce  <= 1'b0;
        end
    end

endmodule

// File: rtl/chip8_timebase.sv
// CHIP-8 timebase: NUM_CH independent fractional clock enables plus a
// stretched system reset built from edges on several request lines.
// Enables keep running while rst_out is high so downstream logic is clocked
// through its own reset.
module chip8_timebase
    import chip8_pkg::*;
#(
    parameter int                 NUM_CH   = NUM_CH_DEFAULT,
    parameter int                 ACC_W    = ACC_W_DEFAULT,
    parameter int                 RST_SRC  = RST_SRC_DEFAULT,
    parameter logic [RST_SRC-1:0] RST_EDGE = RST_EDGE_DEFAULT,
    parameter int                 RST_LEN  = RST_LEN_DEFAULT
) (
    input  logic            clk_sys,
    input  logic            reset_n,
    chip8_timebase_if.slave bus
);
    localparam int               CNT_W      = stretch_cnt_w(RST_LEN);
    localparam logic [CNT_W-1:0] LEN_FULL   = CNT_W'(RST_LEN);
    localparam logic [CNT_W-1:0] LEN_RELOAD = CNT_W'(RST_LEN - 1);

    logic [RST_SRC-1:0] src_q;
    logic [RST_SRC-1:0] src_edge;
    logic [CNT_W-1:0]   stretch_cnt;
    logic               rst_q;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        chip8_frac_ce #(
            .ACC_W (ACC_W)
        ) u_ch (
            .clk_sys (clk_sys),
            .reset_n (reset_n),
            .num     (bus.num_cfg[k*ACC_W +: ACC_W]),
            .den     (bus.den_cfg[k*ACC_W +: ACC_W]),
            .hold    (bus.hold[k]),
            .ce      (bus.ce[k])
        );
    end

    // Keep the previous source levels; loading them during reset means a
    // source already active at release does not count as a new request.
    always_ff @(posedge clk_sys) begin
        src_q <= bus.rst_src;
    end

    // Per-source edge of the selected polarity; all sources merge into one event.
    always_comb begin
        src_edge = (bus.rst_src & ~src_q & RST_EDGE) |
                   (~bus.rst_src & src_q & ~RST_EDGE);
    end

    // Stretch counter: counts the high cycles still owed after this one.
    // Reset parks it at RST_LEN so the power-on stretch runs after release.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            rst_q       <= 1'b1;
            stretch_cnt <= LEN_FULL;
        end else if (|src_edge) begin
            rst_q       <= 1'b1;
            stretch_cnt <= LEN_RELOAD;
        end else if (stretch_cnt != '0) begin
            rst_q       <= 1'b1;
            stretch_cnt <= stretch_cnt - CNT_W'(1);
        end else begin
            rst_q       <= 1'b0;
        end
    end

    assign bus.rst_out = rst_q;

endmodule

// File: tb/tb_chip8_timebase.sv
// Bench for chip8_timebase: directed scenarios for rate, hold and reset
// stretching, then randomized rounds, all checked cycle by cycle against a
// model that counts pulses as floor(t*num/den) and tracks a reset deadline.
module tb_chip8_timebase;
    import chip8_pkg::*;

    localparam int         NUM_CH   = 4;
    localparam int         ACC_W    = 24;
    localparam int         RST_SRC  = 3;
    localparam logic [2:0] RST_EDGE = 3'b011;
    localparam int         RST_LEN  = 16;

    logic clk_sys = 1'b0;
    logic reset_n;

    chip8_timebase_if #(.NUM_CH(NUM_CH), .ACC_W(ACC_W), .RST_SRC(RST_SRC)) bus ();

    chip8_timebase #(
        .NUM_CH   (NUM_CH),
        .ACC_W    (ACC_W),
        .RST_SRC  (RST_SRC),
        .RST_EDGE (RST_EDGE),
        .RST_LEN  (RST_LEN)
    ) dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Clock
    always #5 clk_sys = ~clk_sys;

    // Counters
    int n_vec = 0;
    int n_bad = 0;

    // Reference model state
    longint             cyc     = 0;
    longint             rst_end = -1;
    longint             t_m   [NUM_CH];
    longint             num_a [NUM_CH];
    longint             den_a [NUM_CH];
    logic [NUM_CH-1:0]  exp_ce;
    logic               exp_rst;
    logic [RST_SRC-1:0] prev_src;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic apply_cfg();
        for (int k = 0; k < NUM_CH; k++) begin
            bus.num_cfg[k*ACC_W +: ACC_W] = ACC_W'(num_a[k]);
            bus.den_cfg[k*ACC_W +: ACC_W] = ACC_W'(den_a[k]);
        end
    endtask

    // One clk_sys cycle: predict at the rising edge from the applied inputs,
    // compare on the falling edge.
    task automatic step();
        logic any_edge;
        @(posedge clk_sys);
        cyc++;
        if (!reset_n) begin
            for (int k = 0; k < NUM_CH; k++) t_m[k] = 0;
            exp_ce  = '0;
            rst_end = cyc + RST_LEN;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (bus.hold[k]) begin
                    exp_ce[k] = 1'b0;
                end else if (den_a[k] == 0) begin
                    t_m[k]    = 0;
                    exp_ce[k] = 1'b0;
                end else begin
                    t_m[k]++;
                    exp_ce[k] = ((t_m[k] * num_a[k]) / den_a[k]) !=
                                (((t_m[k] - 1) * num_a[k]) / den_a[k]);
                end
            end
            any_edge = 1'b0;
            for (int i = 0; i < RST_SRC; i++) begin
                if (RST_EDGE[i] ? (bus.rst_src[i] && !prev_src[i])
                                : (!bus.rst_src[i] && prev_src[i]))
                    any_edge = 1'b1;
            end
            if (any_edge) rst_end = cyc + RST_LEN - 1;
        end
        prev_src = bus.rst_src;
        exp_rst  = (cyc <= rst_end);
        @(negedge clk_sys);
        for (int k = 0; k < NUM_CH; k++)
            chk($sformatf("ce%0d@%0d", k, cyc), 64'(bus.ce[k]), 64'(exp_ce[k]));
        chk($sformatf("rst_out@%0d", cyc), 64'(bus.rst_out), 64'(exp_rst));
    endtask

    // Watchdog
    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        longint q0[$];
        longint q2[$];
        longint base, pc, prev, n, first;
        int     n1, rst_hi, bad, cnt25, in_w, idx;

        // Reset state and power-on stretch with rate configs loaded
        reset_n      = 1'b0;
        bus.hold     = '0;
        bus.rst_src  = 3'b100;
        prev_src     = 3'b100;
        num_a = '{1, 4, 3, 7};
        den_a = '{4000, 0, 250, 13};
        apply_cfg();
        repeat (3) step();
        reset_n = 1'b1;

        // 40000 cycles: ch0 1/4000, ch1 off, ch2 3/250
        base = cyc; rst_hi = 0; n1 = 0;
        for (int i = 0; i < 40000; i++) begin
            step();
            pc = cyc - base;
            if (bus.rst_out === 1'b1) rst_hi++;
            if (bus.ce[0] === 1'b1) q0.push_back(pc);
            if (bus.ce[1] === 1'b1) n1++;
            if (bus.ce[2] === 1'b1) q2.push_back(pc);
        end
        chk("por_stretch_len", 64'(rst_hi), 64'(RST_LEN));
        chk("ch0_pulse_count", 64'(q0.size()), 64'd10);
        prev = 0;
        foreach (q0[i]) begin
            chk($sformatf("ch0_gap%0d", i), 64'(q0[i] - prev), 64'd4000);
            prev = q0[i];
        end
        chk("ch1_den0_idle", 64'(n1), 64'd0);
        bad = 0; cnt25 = 0; prev = 0;
        foreach (q2[i]) begin
            if (q2[i] <= 25000) cnt25++;
            if ((q2[i] - prev) != 83 && (q2[i] - prev) != 84) bad++;
            prev = q2[i];
        end
        chk("ch2_count_25000", 64'(cnt25), 64'd300);
        chk("ch2_bad_intervals", 64'(bad), 64'd0);
        bad = 0;
        for (int w = 0; w < 160; w++) begin
            in_w = 0;
            foreach (q2[i]) if (q2[i] > w*250 && q2[i] <= (w+1)*250) in_w++;
            if (in_w != 3) bad++;
        end
        chk("ch2_bad_windows", 64'(bad), 64'd0);

        // ch1 from den=0 to num=den=4: every cycle
        num_a[1] = 4; den_a[1] = 4; apply_cfg();
        n1 = 0;
        repeat (20) begin
            step();
            if (bus.ce[1] === 1'b1) n1++;
        end
        chk("ch1_every_cycle", 64'(n1), 64'd20);

        // ch0 1/1000 with a 500-cycle hold mid-count
        den_a[0] = 0; apply_cfg(); step();
        num_a[0] = 1; den_a[0] = 1000; apply_cfg();
        first = -1;
        for (int c = 1; c <= 1600; c++) begin
            bus.hold[0] = (c >= 301 && c <= 800);
            step();
            if (bus.ce[0] === 1'b1 && first < 0) first = c;
        end
        bus.hold[0] = 1'b0;
        chk("hold_delay_first_ce", 64'(first), 64'd1500);

        // Falling edge on source 2 gives one stretch
        bus.rst_src[2] = 1'b0;
        n = 0;
        step();
        while (bus.rst_out === 1'b1 && n < 100) begin n++; step(); end
        chk("src2_fall_stretch", 64'(n), 64'(RST_LEN));
        bus.rst_src[2] = 1'b1;
        repeat (5) step();

        // Source 0 rises 10 cycles into a stretch and reloads it
        bus.rst_src[2] = 1'b0;
        n = 0;
        repeat (10) begin
            step();
            if (bus.rst_out === 1'b1) n++;
        end
        bus.rst_src[0] = 1'b1;
        step();
        while (bus.rst_out === 1'b1 && n < 200) begin n++; step(); end
        chk("src0_reload_stretch", 64'(n), 64'(RST_LEN + 10));
        bus.rst_src = 3'b100;
        repeat (5) step();

        // reset_n mid-stretch while source 1 stays high
        bus.rst_src[1] = 1'b1;
        repeat (5) step();
        reset_n = 1'b0;
        repeat (3) begin
            step();
            chk("ce_all_zero_in_reset", 64'(bus.ce), 64'd0);
        end
        reset_n = 1'b1;
        n = 0;
        step();
        while (bus.rst_out === 1'b1 && n < 100) begin n++; step(); end
        chk("por_with_src1_held", 64'(n), 64'(RST_LEN));
        n = 0;
        repeat (30) begin
            step();
            if (bus.rst_out !== 1'b0) n++;
        end
        chk("no_extra_stretch", 64'(n), 64'd0);
        bus.rst_src[1] = 1'b0;
        step();

        // Randomized rounds
        for (int r = 0; r < 30; r++) begin
            if ($urandom_range(0, 3) == 0) begin
                reset_n = 1'b0;
                repeat (2) step();
                reset_n = 1'b1;
            end
            bus.hold = '0;
            for (int k = 0; k < NUM_CH; k++) den_a[k] = 0;
            apply_cfg();
            step();
            for (int k = 0; k < NUM_CH; k++) begin
                num_a[k] = $urandom_range(0, 20);
                den_a[k] = $urandom_range(0, 40);
            end
            apply_cfg();
            for (int c = 0; c < 150; c++) begin
                if ($urandom_range(0, 9) == 0) begin
                    idx = $urandom_range(0, NUM_CH - 1);
                    bus.hold[idx] = ~bus.hold[idx];
                end
                if ($urandom_range(0, 59) == 0) begin
                    idx = $urandom_range(0, RST_SRC - 1);
                    bus.rst_src[idx] = ~bus.rst_src[idx];
                end
                step();
            end
        end

        // Report
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/chip8_timebase.md
CHIP8_TIMEBASE -- requirements
Module: chip8_timebase

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of clock-enable channels.
REQ-002 SHALL have parameter ACC_W, default 24: accumulator, numerator and denominator width.
REQ-003 SHALL have parameter RST_SRC, default 3: number of reset-request sources.
REQ-004 SHALL have parameter RST_EDGE, default 3'b011: per-source edge select (1 = rising, 0 = falling).
REQ-005 SHALL have parameter RST_LEN, default 16: reset-stretch length in clk_sys cycles, minimum 1.
REQ-006 SHALL have port clk_sys, in, 1: single clock; all logic on its rising edge.
REQ-007 SHALL have port reset_n, in, 1: synchronous, active-low reset.
REQ-008 SHALL have port num_cfg, in, NUM_CH*ACC_W: per-channel rate numerator; channel k occupies bits [k*ACC_W +: ACC_W].
REQ-009 SHALL have port den_cfg, in, NUM_CH*ACC_W: per-channel rate denominator, same packing as num_cfg.
REQ-010 SHALL have port hold, in, NUM_CH: per-channel pause.
REQ-011 SHALL have port rst_src, in, RST_SRC: level reset-request sources (button, download, error).
REQ-012 SHALL have port ce, out, NUM_CH: one-cycle clock-enable pulses, registered.
REQ-013 SHALL have port rst_out, out, 1: stretched active-high system reset, registered.

Function
REQ-014 Each channel SHALL keep an ACC_W-bit accumulator acc, updated every cycle from the current num_cfg/den_cfg.
- If acc+num >= den: ce=1 next cycle and acc <= acc+num-den.
- Otherwise: ce=0 and acc <= acc+num.
REQ-015 The acc+num comparison SHALL be done at ACC_W+1 bits; overflow is not permitted.
REQ-016 Long-run ce rate SHALL be exactly num/den of clk_sys, with no cumulative drift (fractional division).
REQ-017 If den==0, the channel SHALL output ce=0 and hold acc at 0.
REQ-018 If num>=den and den!=0, the channel SHALL output ce=1 every cycle with acc=0.
REQ-019 If acc>=den after a config change, acc SHALL be cleared to 0 that cycle and ce=0.
REQ-020 While hold[k]=1, channel k SHALL freeze acc, force ce[k]=0 and drop no phase; it resumes from the frozen acc.
REQ-021 Sources SHALL be registered into src_q; the edge for bit i is src & ~src_q if RST_EDGE[i]=1, ~src & src_q otherwise.
REQ-022 Any edge SHALL set rst_out=1 on the next cycle and load a stretch counter so rst_out stays high exactly RST_LEN cycles.
REQ-023 An edge arriving while rst_out is high SHALL reload the counter to a full RST_LEN.
REQ-024 Simultaneous edges on several sources SHALL be treated as one event.
REQ-025 ce generation SHALL continue while rst_out=1; downstream logic needs clocks during reset.

Reset
REQ-026 While reset_n=0:
- every acc=0 and ce=0;
- src_q <= rst_src, so no edge is seen on release;
- rst_out=1.
REQ-027 After reset_n rises, rst_out SHALL stay high exactly RST_LEN further cycles, then fall (power-on stretch).
REQ-028 reset_n asserted mid-stretch or mid-count SHALL override all state within one cycle.

Structure
REQ-029 A shared package chip8_pkg SHALL hold the default ACC_W, NUM_CH and RST_LEN values and the channel-index constants CH_CPU_FAST=0, CH_CPU_SLOW=1, CH_TIMER=2, CH_AUDIO=3.
REQ-030 One sub-module, chip8_frac_ce, SHALL implement a single channel (REQ-014..020) and be instantiated NUM_CH times in a generate loop.
REQ-031 Reset-edge detection and stretch logic SHALL stay in the top level.

Verification
REQ-032 Ch0 num=1, den=4000, run 40000 cycles -> exactly 10 ce pulses, spacing 4000.
REQ-033 Ch2 num=3, den=250 -> every interval 83 or 84 cycles; exactly 3 ce per 250-cycle window; 300 pulses in 25000 cycles.
REQ-034 Ch1 den=0, then den=4 with num=4 -> ce stays 0, then ce=1 every cycle.
REQ-035 hold[0]=1 for 500 cycles mid-count (num=1, den=1000) -> next ce arrives exactly 500 cycles later than without hold.
REQ-036 Release reset_n with RST_LEN=16 -> rst_out high 16 cycles.
- Then rst_src[2] falls (RST_EDGE[2]=0) -> rst_out high 16 cycles from the next cycle.
- A rst_src[0] rise 10 cycles in -> rst_out extended to 26 cycles total.
REQ-037 reset_n pulsed low while rst_src[1]=1 is held -> no extra stretch after the power-on stretch; ce all 0 during reset_n=0.
